// File: rtl/crc_check_sequencer.sv
// crc_check_sequencer
// Sequences one serial CRC-4 check pass per codeword: accept, load the
// decoder, shift it CW_WIDTH times, sample its data/error, then present the
// result on the output stream.
// Optional feature: define CRC_SEQ_ERR_CNT_EN to build the saturating
// mismatch counter (err_count / err_clr).
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// in_ready is a pure state decode (high only in IDLE); out_valid is high only
// in OUT and its payload is held until out_ready is seen.
module crc_check_sequencer #(
    parameter int CW_WIDTH      = 12,
    parameter int DATA_WIDTH    = 8,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CW_WIDTH-1:0]      in_data,
    output logic                     dec_load,
    output logic                     dec_shift_en,
    output logic [CW_WIDTH-1:0]      dec_encoded_data,
    input  logic [DATA_WIDTH-1:0]    dec_data,
    input  logic                     dec_error,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_error,
    output logic                     busy,
    input  logic                     err_clr,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);

    localparam int CNT_W = $clog2(CW_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(CW_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SHIFT = 3'd2,
        S_CHECK = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [CNT_W-1:0]      r_shift_cnt;
    logic [CW_WIDTH-1:0]   r_codeword;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_error;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: one full pass per accepted codeword
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_next_state = S_LOAD;
            S_LOAD:  w_next_state = S_SHIFT;
            S_SHIFT: if (r_shift_cnt == LAST_SHIFT) w_next_state = S_CHECK;
            S_CHECK: w_next_state = S_OUT;
            S_OUT:   if (out_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output decode: every strobe is a function of the state register only
    always_comb begin
        in_ready     = 1'b0;
        dec_load     = 1'b0;
        dec_shift_en = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b1;
        case (r_state)
            S_IDLE:  begin in_ready = 1'b1; busy = 1'b0; end
            S_LOAD:  dec_load     = 1'b1;
            S_SHIFT: dec_shift_en = 1'b1;
            S_OUT:   out_valid    = 1'b1;
            default: ;
        endcase
    end

    // Datapath: capture codeword on accept, count shifts, sample decoder in CHECK
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_codeword  <= '0;
            r_shift_cnt <= '0;
            r_out_data  <= '0;
            r_out_error <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE:  if (in_valid) r_codeword <= in_data;
                S_LOAD:  r_shift_cnt <= '0;
                S_SHIFT: r_shift_cnt <= r_shift_cnt + 1'b1;
                S_CHECK: begin
                    r_out_data  <= dec_data;
                    r_out_error <= dec_error;
                end
                default: ;
            endcase
        end
    end

    assign dec_encoded_data = r_codeword;
    assign out_data         = r_out_data;
    assign out_error        = r_out_error;

`ifdef CRC_SEQ_ERR_CNT_EN
    logic [ERR_CNT_WIDTH-1:0] r_err_count;

    // Saturating mismatch counter; a clear overrides a same-cycle increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count <= '0;
        end else if (err_clr) begin
            r_err_count <= '0;
        end else if (r_state == S_CHECK && dec_error && !(&r_err_count)) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

    assign err_count = r_err_count;
`else
    logic w_unused_err_clr;

    assign w_unused_err_clr = err_clr;
    assign err_count        = '0;
`endif

endmodule

// File: tb/tb_crc_check_sequencer.sv
// Bench for crc_check_sequencer: serial CRC-4 decoder model on the dec_*
// side, random codewords checked against a polynomial long-division model.
module tb_crc_check_sequencer;

    localparam int CW = 12;
    localparam int DW = 8;
    localparam int EW = 16;

`ifdef CRC_SEQ_ERR_CNT_EN
    localparam bit ERRCNT_EN = 1'b1;
`else
    localparam bit ERRCNT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_data;
    logic          dec_load;
    logic          dec_shift_en;
    logic [CW-1:0] dec_encoded_data;
    logic [DW-1:0] dec_data;
    logic          dec_error;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_error;
    logic          busy;
    logic          err_clr;
    logic [EW-1:0] err_count;

    int checks = 0;
    int failures = 0;

    crc_check_sequencer #(.CW_WIDTH(CW), .DATA_WIDTH(DW), .ERR_CNT_WIDTH(EW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .dec_load(dec_load), .dec_shift_en(dec_shift_en),
        .dec_encoded_data(dec_encoded_data),
        .dec_data(dec_data), .dec_error(dec_error),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_error(out_error),
        .busy(busy), .err_clr(err_clr), .err_count(err_count)
    );

    // clock / reset
    always #5 clk = ~clk;

    // serial CRC-4 decoder model (x^4 + x + 1), driven only by the strobes
    logic [CW-1:0] dm_sh;
    logic [3:0]    dm_rem;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dm_sh <= '0; dm_rem <= '0; dec_data <= '0;
        end else if (dec_load) begin
            dm_sh <= dec_encoded_data; dm_rem <= '0;
            dec_data <= dec_encoded_data[CW-1:CW-DW];
        end else if (dec_shift_en) begin
            dm_sh  <= dm_sh << 1;
            dm_rem <= {dm_rem[2:0], 1'b0} ^ (((dm_rem[3] ^ dm_sh[CW-1]) != 1'b0) ? 4'h3 : 4'h0);
        end
    end
    assign dec_error = (dm_rem != 4'h0);

    // passive monitor
    int          cyc = 0;
    int          n_load = 0;
    int          n_shift = 0;
    int          n_outv = 0;
    bit          overlap = 1'b0;
    int          accept_cyc[$];
    logic [DW:0] out_q[$];
    always @(posedge clk) begin
        cyc++;
        if (dec_load) n_load++;
        if (dec_shift_en) n_shift++;
        if (dec_load && dec_shift_en) overlap = 1'b1;
        if (out_valid) n_outv++;
        if (rst_n && in_valid && in_ready) accept_cyc.push_back(cyc);
        if (rst_n && out_valid && out_ready) out_q.push_back({out_error, out_data});
    end

    // reference model: long division by x^4 + x + 1
    function automatic logic [3:0] crc_rem(input logic [CW-1:0] cw);
        logic [CW-1:0] r;
        logic [CW-1:0] g;
        r = cw;
        for (int i = CW - 1; i >= 4; i--) begin
            if (r[i]) begin
                g = CW'(5'b10011) << (i - 4);
                r = r ^ g;
            end
        end
        return r[3:0];
    endfunction

    function automatic logic [CW-1:0] make_good(input logic [DW-1:0] d);
        logic [CW-1:0] base;
        base = {d, 4'h0};
        return base | CW'(crc_rem(base));
    endfunction

    logic [DW:0] exp_q[$];
    int          model_errcnt = 0;

    // driver: one codeword through a full pass, with optional output stall
    task automatic send_one(input logic [CW-1:0] cw, input int stall, input bit clr_in_check);
        int          lat;
        int          ln;
        int          sn;
        int          acc_n;
        bit          unstable;
        bit          bad;
        logic [DW:0] exp;
        logic [DW:0] held;
        lat = 0;
        while (!in_ready && lat < 50) begin @(posedge clk); #1; lat++; end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL send_ready got=%b exp=1", in_ready); end
        bad = (crc_rem(cw) != 4'h0);
        exp_q.push_back({bad, cw[CW-1:CW-DW]});
        if (clr_in_check) model_errcnt = 0;
        else if (ERRCNT_EN && bad && model_errcnt < 65535) model_errcnt++;
        out_q.delete();
        ln = n_load; sn = n_shift;
        out_ready = (stall == 0);
        in_valid = 1'b1; in_data = cw;
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = CW'($urandom);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
            err_clr = clr_in_check && (lat == 13);
        end
        err_clr = 1'b0;
        exp = exp_q.pop_front();
        checks++;
        if (lat != 14) begin failures++; $display("FAIL latency got=%0d exp=14", lat); end
        checks++;
        if (n_load - ln != 1) begin failures++; $display("FAIL load_count got=%0d exp=1", n_load - ln); end
        checks++;
        if (n_shift - sn != CW) begin failures++; $display("FAIL shift_count got=%0d exp=%0d", n_shift - sn, CW); end
        checks++;
        if (out_data !== exp[DW-1:0]) begin failures++; $display("FAIL out_data cw=%h got=%h exp=%h", cw, out_data, exp[DW-1:0]); end
        checks++;
        if (out_error !== exp[DW]) begin failures++; $display("FAIL out_error cw=%h got=%b exp=%b", cw, out_error, exp[DW]); end
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL out_state in_ready=%b busy=%b exp=0/1", in_ready, busy); end
        if (stall > 0) begin
            unstable = 1'b0;
            held = {out_error, out_data};
            acc_n = accept_cyc.size();
            for (int k = 0; k < stall; k++) begin
                in_valid = ($urandom_range(0, 1) == 1); in_data = CW'($urandom);
                @(posedge clk); #1;
                if (out_valid !== 1'b1 || {out_error, out_data} !== held || in_ready !== 1'b0) unstable = 1'b1;
            end
            in_valid = 1'b0;
            checks++;
            if (unstable) begin failures++; $display("FAIL stall_stable got=1 exp=0"); end
            checks++;
            if (accept_cyc.size() != acc_n) begin failures++; $display("FAIL stall_accept got=%0d exp=%0d", accept_cyc.size(), acc_n); end
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL return_idle out_valid=%b in_ready=%b exp=0/1", out_valid, in_ready); end
        checks++;
        if (out_q.size() != 1 || (out_q.size() == 1 && out_q[0] !== exp)) begin failures++; $display("FAIL handshake n=%0d exp=1 data_exp=%h", out_q.size(), exp); end
        checks++;
        if (err_count !== EW'(model_errcnt)) begin failures++; $display("FAIL err_count got=%0d exp=%0d", err_count, model_errcnt); end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; err_clr = 1'b0;
        model_errcnt = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL reset_ctrl in_ready=%b busy=%b exp=1/0", in_ready, busy); end
        checks++;
        if (dec_load !== 1'b0 || dec_shift_en !== 1'b0 || dec_encoded_data !== '0) begin
            failures++; $display("FAIL reset_dec load=%b shift=%b enc=%h exp=0", dec_load, dec_shift_en, dec_encoded_data);
        end
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_error !== 1'b0 || err_count !== '0) begin
            failures++; $display("FAIL reset_out v=%b d=%h e=%b cnt=%0d exp=0", out_valid, out_data, out_error, err_count);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed;
        send_one(12'h013, 0, 1'b0);
        send_one(12'h012, 0, 1'b0);
    endtask

    task automatic test_stall;
        send_one(12'h5A7, 20, 1'b0);
    endtask

    task automatic test_random;
        logic [CW-1:0] cw;
        for (int n = 0; n < 16; n++) begin
            if ($urandom_range(0, 1) == 1) cw = make_good(DW'($urandom));
            else cw = CW'($urandom);
            send_one(cw, $urandom_range(0, 3), 1'b0);
        end
    endtask

    task automatic test_back_to_back;
        int wait_n;
        accept_cyc.delete(); out_q.delete();
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 12'h000;
        wait_n = 0;
        while (accept_cyc.size() < 1 && wait_n < 40) begin @(posedge clk); #1; wait_n++; end
        in_data = 12'h013;
        while (accept_cyc.size() < 2 && wait_n < 80) begin @(posedge clk); #1; wait_n++; end
        in_valid = 1'b0;
        while (out_q.size() < 2 && wait_n < 120) begin @(posedge clk); #1; wait_n++; end
        out_ready = 1'b0;
        checks++;
        if (accept_cyc.size() != 2) begin
            failures++; $display("FAIL b2b_accepts got=%0d exp=2", accept_cyc.size());
        end else begin
            checks++;
            if (accept_cyc[1] - accept_cyc[0] != 16) begin failures++; $display("FAIL b2b_spacing got=%0d exp=16", accept_cyc[1] - accept_cyc[0]); end
        end
        checks++;
        if (out_q.size() != 2) begin
            failures++; $display("FAIL b2b_results got=%0d exp=2", out_q.size());
        end else begin
            checks++;
            if (out_q[0] !== 9'h000 || out_q[1] !== 9'h001) begin failures++; $display("FAIL b2b_data got=%h,%h exp=000,001", out_q[0], out_q[1]); end
        end
    endtask

    task automatic test_reset_mid;
        int ov;
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 12'h3C5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (dec_shift_en !== 1'b1) begin failures++; $display("FAIL mid_in_shift got=%b exp=1", dec_shift_en); end
        rst_n = 1'b0;
        model_errcnt = 0;
        #1;
        checks++;
        if (dec_shift_en !== 1'b0 || dec_load !== 1'b0 || dec_encoded_data !== '0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL mid_reset_ctrl shift=%b enc=%h busy=%b rdy=%b exp=0/0/0/1", dec_shift_en, dec_encoded_data, busy, in_ready);
        end
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_error !== 1'b0 || err_count !== '0) begin
            failures++; $display("FAIL mid_reset_out v=%b d=%h e=%b cnt=%0d exp=0", out_valid, out_data, out_error, err_count);
        end
        @(posedge clk); #3;
        rst_n = 1'b1;
        ov = n_outv;
        out_ready = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (n_outv != ov) begin failures++; $display("FAIL mid_no_result got=%0d exp=%0d", n_outv - ov, 0); end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_idle got=%b exp=1", in_ready); end
    endtask

    task automatic test_err_count;
`ifdef CRC_SEQ_ERR_CNT_EN
        force dut.r_err_count = 16'hFFFF;
        @(posedge clk); #1;
        release dut.r_err_count;
        model_errcnt = 65535;
`endif
        send_one(12'h012, 0, 1'b0);
        send_one(12'h7F0, 0, 1'b1);
        send_one(12'h012, 0, 1'b0);
    endtask

    task automatic test_strobe_overlap;
        checks++;
        if (overlap) begin failures++; $display("FAIL strobe_overlap got=1 exp=0"); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_err_count();
        test_strobe_overlap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
